// File: rtl/peripheral_pulse_gen.sv
// peripheral_pulse_gen
// Turns a noisy asynchronous push-button level into one clean single-cycle
// pulse per press: polarity normalisation, two-flop synchronizer, optional
// debouncer, then rising-edge detection on the debounced level.
// Optional feature macro: PERIPHERAL_PULSE_DEBOUNCE_EN
//   defined   -> a stability counter filters the synchronized level
//   undefined -> the debounced level simply follows the synchronizer
//                (every synchronized transition is accepted)
module peripheral_pulse_gen #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
    input  logic inbutton,
    input  logic clk,
    input  logic reset,
    output logic outpulse
);

    // Internal convention: 1 means "pressed" regardless of board wiring.
    logic pressed_raw;
    logic s1;
    logic s2;
    logic deb;
    logic deb_next;

    assign pressed_raw = inbutton ^ BUTTON_ACTIVE_LOW;

    // A zero-length stability window has no meaning; refuse to elaborate.
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
        $error("peripheral_pulse_gen: DEBOUNCE_CYCLES must be >= 1");
    end

    // Two-flop synchronizer bringing the raw button into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= pressed_raw;
            s2 <= s1;
        end
    end

`ifdef PERIPHERAL_PULSE_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Accept a new level only after it has disagreed with deb for DEBOUNCE_CYCLES edges in a row.
    always_comb begin
        deb_next = deb;
        cnt_next = cnt;
        if (s2 == deb) begin
            cnt_next = '0;
        end else if (cnt == CNT_LAST) begin
            deb_next = s2;
            cnt_next = '0;
        end else begin
            cnt_next = cnt + 1'b1;
        end
    end

    // Stability counter register; reset discards any partial count.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end
`else
    assign deb_next = s2;
`endif

    // Debounced level register and registered rising-edge pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb      <= 1'b0;
            outpulse <= 1'b0;
        end else begin
            deb      <= deb_next;
            outpulse <= deb_next & ~deb;
        end
    end

endmodule

// File: tb/tb_peripheral_pulse_gen.sv
// tb_peripheral_pulse_gen
// Two instances: dut_a (DEBOUNCE_CYCLES=4, active-low button) and
// dut_b (DEBOUNCE_CYCLES=8, active-high button). Every cycle both outputs are
// compared with a reference model; a segment table and hand-written
// sequences add pulse-count and latency checks. Works with or without
// PERIPHERAL_PULSE_DEBOUNCE_EN.
module tb_peripheral_pulse_gen;

    localparam int DC_A = 4;
    localparam bit AL_A = 1'b1;
    localparam int DC_B = 8;
    localparam bit AL_B = 1'b0;

`ifdef PERIPHERAL_PULSE_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
`else
    localparam bit DEB_ON = 1'b0;
`endif

    // Press-to-pulse latency in edges, counting from the edge that first samples the press.
    localparam int LAT_A = DEB_ON ? DC_A + 2 : 3;
    localparam int LAT_B = DEB_ON ? DC_B + 2 : 3;

    logic clk = 1'b0;
    logic reset;
    logic btn_a;
    logic btn_b;
    logic pulse_a;
    logic pulse_b;

    always #5 clk = ~clk;

    peripheral_pulse_gen #(
        .DEBOUNCE_CYCLES  (DC_A),
        .BUTTON_ACTIVE_LOW(AL_A)
    ) dut_a (
        .inbutton(btn_a),
        .clk     (clk),
        .reset   (reset),
        .outpulse(pulse_a)
    );

    peripheral_pulse_gen #(
        .DEBOUNCE_CYCLES  (DC_B),
        .BUTTON_ACTIVE_LOW(AL_B)
    ) dut_b (
        .inbutton(btn_b),
        .clk     (clk),
        .reset   (reset),
        .outpulse(pulse_b)
    );

    int compared   = 0;
    int mismatched = 0;
    int cnt_a;
    int cnt_b;

    // Reference model state per instance: synchronizer stages, accepted level,
    // and a window of the most recent synchronized samples (newest at index 0).
    int m_dc[2];
    bit m_s1[2];
    bit m_s2[2];
    bit m_deb[2];
    bit m_pulse[2];
    bit m_hist[2][16];
    int m_hlen[2];

    typedef struct {
        bit rst;
        bit a_press;
        bit b_press;
        int cycles;
        int exp_a;
        int exp_b;
    } seg_t;

    seg_t segs[8];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive inputs in "pressed" terms; the bench converts to each button's wiring.
    task automatic applyStimulus(input bit rst, input bit a_press, input bit b_press);
        reset = rst;
        btn_a = a_press ^ AL_A;
        btn_b = b_press ^ AL_B;
    endtask

    // Rule: the accepted level flips once the last DC synchronized samples all
    // disagree with it; a pulse marks each 0->1 change of the accepted level.
    task automatic model_one(input int i, input bit rst, input bit btn, input bit alow);
        bit old_s2;
        bit new_deb;
        bit all_away;
        if (rst) begin
            m_s1[i]    = 1'b0;
            m_s2[i]    = 1'b0;
            m_deb[i]   = 1'b0;
            m_pulse[i] = 1'b0;
            m_hlen[i]  = 0;
            return;
        end
        old_s2 = m_s2[i];
`ifdef PERIPHERAL_PULSE_DEBOUNCE_EN
        for (int j = 15; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
        m_hist[i][0] = old_s2;
        if (m_hlen[i] < 16) m_hlen[i]++;
        all_away = (m_hlen[i] >= m_dc[i]);
        for (int j = 0; j < m_dc[i]; j++) begin
            if (m_hist[i][j] == m_deb[i]) all_away = 1'b0;
        end
        new_deb = all_away ? ~m_deb[i] : m_deb[i];
`else
        all_away = 1'b0;
        new_deb  = old_s2 | all_away;
`endif
        m_pulse[i] = new_deb & ~m_deb[i];
        m_deb[i]   = new_deb;
        m_s2[i]    = m_s1[i];
        m_s1[i]    = btn ^ alow;
    endtask

    // One clock: advance the model on the edge, compare both outputs 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_one(0, reset, btn_a, AL_A);
        model_one(1, reset, btn_b, AL_B);
        #1;
        checkOutput("pulse_a", pulse_a, m_pulse[0]);
        checkOutput("pulse_b", pulse_b, m_pulse[1]);
        if (pulse_a === 1'b1) cnt_a++;
        if (pulse_b === 1'b1) cnt_b++;
    endtask

    initial begin
        int first;
        int len;

        m_dc[0] = DC_A;
        m_dc[1] = DC_B;
        m_hlen[0] = 0;
        m_hlen[1] = 0;

        // rst, a_press, b_press, cycles, expected pulses a, expected pulses b
        segs[0] = '{1'b1, 1'b0, 1'b0,  3, 0, 0};
        segs[1] = '{1'b0, 1'b0, 1'b0, 20, 0, 0};
        segs[2] = '{1'b0, 1'b1, 1'b1, 20, 1, 1};
        segs[3] = '{1'b0, 1'b0, 1'b0, 20, 0, 0};
        segs[4] = '{1'b0, 1'b1, 1'b1, 50, 1, 1};
        segs[5] = '{1'b0, 1'b0, 1'b0, 10, 0, 0};
        segs[6] = '{1'b0, 1'b1, 1'b1, 20, 1, 1};
        segs[7] = '{1'b0, 1'b0, 1'b0, 20, 0, 0};

        applyStimulus(1'b1, 1'b0, 1'b0);

        for (int s = 0; s < 8; s++) begin
            applyStimulus(segs[s].rst, segs[s].a_press, segs[s].b_press);
            cnt_a = 0;
            cnt_b = 0;
            repeat (segs[s].cycles) tick();
            checkOutput($sformatf("seg%0d_count_a", s), cnt_a, segs[s].exp_a);
            checkOutput($sformatf("seg%0d_count_b", s), cnt_b, segs[s].exp_b);
        end

        // Clean press on dut_a: pulse position and single pulse while held.
        applyStimulus(1'b0, 1'b1, 1'b0);
        cnt_a = 0;
        first = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (pulse_a === 1'b1 && first < 0) first = n;
        end
        checkOutput("press_latency_a", first, LAT_A);
        checkOutput("press_count_a", cnt_a, 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (20) tick();

        // Bounce on dut_a: pressed, released, pressed, released, then held.
        cnt_a = 0;
        first = -1;
        for (int n = 1; n <= 24; n++) begin
            applyStimulus(1'b0, (n >= 5) || (n % 2 == 1), 1'b0);
            tick();
            if (pulse_a === 1'b1 && first < 0) first = n;
        end
        checkOutput("bounce_first_a", first, DEB_ON ? 4 + LAT_A : 3);
        checkOutput("bounce_count_a", cnt_a, DEB_ON ? 1 : 3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (20) tick();

        // One-cycle glitch on dut_a.
        cnt_a = 0;
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (20) tick();
        checkOutput("glitch_count_a", cnt_a, DEB_ON ? 0 : 1);

        // Reset mid-count on dut_b, button held through reset.
        cnt_b = 0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (7) tick();
        checkOutput("pre_reset_count_b", cnt_b, DEB_ON ? 0 : 1);
        cnt_b = 0;
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (2) tick();
        checkOutput("in_reset_count_b", cnt_b, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        cnt_b = 0;
        first = -1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (pulse_b === 1'b1 && first < 0) first = n;
        end
        checkOutput("post_reset_latency_b", first, LAT_B);
        checkOutput("post_reset_count_b", cnt_b, 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (20) tick();

        // Randomized runs of varying length, occasional reset, model-checked every cycle.
        for (int k = 0; k < 60; k++) begin
            len = $urandom_range(1, 14);
            applyStimulus($urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat (len) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
